decode_stage: RTL
=================

# decode_stage

Instruction decode stage sitting directly upstream of the register file. Accepts a fetched 32-bit RV32I instruction over a valid/ready handshake and holds it in a one-entry pipeline register. It extracts `rs1`/`rs2`/`rd`, the write enable and the sign-extended immediate, and drives them to the register file read ports and the execute stage. An optional scoreboard stalls issue on read-after-write hazards until writeback clears the destination.

## Interface
- `XLEN`, default 32: data/immediate/PC width.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  fetch offers an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  instruction address.
- `flush`  in  1  discard the held instruction.
- `wb_valid`  in  1  writeback retires a register write.
- `wb_rd`  in  5  register being written back.
- `out_valid`  out  1  decoded instruction issuable.
- `out_ready`  in  1  execute accepts.
- `rs1`, `rs2`, `rd`  out  5 each  register file indices.
- `we`  out  1  instruction writes `rd`.
- `imm`  out  XLEN  sign-extended immediate.
- `opcode`  out  7; `funct3`  out  3; `funct7`  out  7.
- `out_pc`  out  XLEN  PC of held instruction.
- `illegal`  out  1  unrecognised opcode.

## Operation
- Holding register `hold_valid` plus stored instruction/PC; all outputs decode combinationally from the stored word.
- `in_ready = !hold_valid || (out_valid && out_ready)`. Accept on `in_valid && in_ready`.
- `out_valid = hold_valid && !hazard && !flush`.
- Formats by `opcode`:
  - R `0110011`: imm=0.
  - I `0010011`/`0000011`/`1100111`: imm=sext(instr[31:20]).
  - S `0100011`: sext({[31:25],[11:7]}).
  - B `1100011`: sext({[31],[7],[30:25],[11:8],0}).
  - U `0110111`/`0010111`: {[31:12],12'b0}.
  - J `1101111`: sext({[31],[19:12],[20],[30:21],0}).
- `we`=1 for R, I, U, J; 0 for S and B. `we` is forced to 0 when `rd`=0.
- Source usage:
  - `uses_rs1`: R, I, S, B.
  - `uses_rs2`: R, S, B.
- Any other opcode: `illegal`=1, `we`=0, imm=0. The instruction still issues so execute can trap.
- Scoreboard: 32-bit `busy` vector; `busy[0]` is hard-wired 0.
  - `hazard = (uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2])`.
  - On issue (`out_valid && out_ready && we`), set `busy[rd]`.
  - On `wb_valid`, clear `busy[wb_rd]`.
  - If set and clear hit the same index in the same cycle, set wins.
- `flush`: clears `hold_valid` at the next edge. It blocks issue in the current cycle and leaves `busy` untouched. If `in_valid` and `flush` occur together, the new instruction is loaded and the old one is discarded (`in_ready` already high or low per rule above).

## Timing
- Reset (async): `hold_valid`=0, `busy`=0, stored instruction=0, `out_pc`=0. Resulting outputs: `out_valid`=0, `in_ready`=1, `we`=0, `illegal`=1 (opcode 0), imm=0, `rs1`/`rs2`/`rd`=0.
- Latency: an instruction accepted at edge N presents `out_valid` in the cycle after edge N, provided no hazard exists.
- Throughput: one instruction per cycle with `out_ready` held high and no hazards.
- `hazard` uses registered `busy` only, so a writeback clear at edge M unblocks issue in the cycle after edge M. There is no same-cycle bypass.
- While `out_valid && !out_ready`, or while stalled by a hazard, all decoded outputs stay stable.
- Reset mid-stall drops the held instruction and clears all busy bits.

## Configuration
- `DECODE_SCOREBOARD_EN` defined: scoreboard and hazard stall as described.
- Undefined: no `busy` storage; `hazard` is constant 0; `wb_valid`/`wb_rd` are ignored. Software scheduling is responsible for hazards.

## Test plan
- Reset, then in `0x00300113` (addi x2,x0,3) with `out_ready`=1 -> next cycle `out_valid`=1, `rd`=2, `rs1`=0, imm=3, `we`=1, `illegal`=0.
- addi x2 issued, then `0x00210233` (add x4,x2,x2) -> `out_valid`=0 and `in_ready`=0 until `wb_valid`=1 with `wb_rd`=2. `out_valid`=1 one cycle later, `rs1`=`rs2`=2, `rd`=4. This stall applies only when `DECODE_SCOREBOARD_EN` is defined; without it, the add issues immediately.
- `0x00412423` (sw x4,8(x2)) -> `we`=0, imm=8, `rs1`=2, `rs2`=4, `funct3`=2.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0, outputs unchanged. Then `out_ready`=1 -> next instruction appears one cycle later.
- `0xFFFFFFFF` -> `illegal`=1, `we`=0, `out_valid`=1.
- Assert `reset` while stalled on x2 -> `out_valid`=0 and `in_ready`=1 immediately. After release, add x4,x2,x2 issues one cycle after accept.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry holding register, field/immediate decode and an
// optional RAW scoreboard enabled by defining DECODE_SCOREBOARD_EN.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            we,
  output logic [XLEN-1:0] imm,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] out_pc,
  output logic            illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic [XLEN-1:0] sext_xlen(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic            hold_valid_r;
  logic [31:0]     instr_r;
  logic [XLEN-1:0] pc_r;

  logic [31:0]     imm32_s;
  logic            we_fmt_s;
  logic            uses_rs1_s;
  logic            uses_rs2_s;
  logic            illegal_s;
  logic            hazard_s;
  logic            issue_s;
  logic            accept_s;

  assign opcode = instr_r[6:0];
  assign rd     = instr_r[11:7];
  assign funct3 = instr_r[14:12];
  assign rs1    = instr_r[19:15];
  assign rs2    = instr_r[24:20];
  assign funct7 = instr_r[31:25];
  assign out_pc = pc_r;

  // Format decode of the held instruction word
  always_comb begin
    imm32_s    = 32'h0000_0000;
    we_fmt_s   = 1'b0;
    uses_rs1_s = 1'b0;
    uses_rs2_s = 1'b0;
    illegal_s  = 1'b0;
    case (instr_r[6:0])
      OP_R: begin
        we_fmt_s   = 1'b1;
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm32_s    = {{20{instr_r[31]}}, instr_r[31:20]};
        we_fmt_s   = 1'b1;
        uses_rs1_s = 1'b1;
      end
      OP_STORE: begin
        imm32_s    = {{20{instr_r[31]}}, instr_r[31:25], instr_r[11:7]};
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
      end
      OP_BRANCH: begin
        imm32_s    = {{19{instr_r[31]}}, instr_r[31], instr_r[7],
                      instr_r[30:25], instr_r[11:8], 1'b0};
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm32_s  = {instr_r[31:12], 12'h000};
        we_fmt_s = 1'b1;
      end
      OP_JAL: begin
        imm32_s  = {{11{instr_r[31]}}, instr_r[31], instr_r[19:12],
                    instr_r[20], instr_r[30:21], 1'b0};
        we_fmt_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  assign imm     = sext_xlen(imm32_s);
  assign illegal = illegal_s;
  assign we      = we_fmt_s && (instr_r[11:7] != 5'd0);

  // Flush only blocks issue; the held word is dropped at the next edge.
  assign out_valid = hold_valid_r && !hazard_s && !flush;
  assign issue_s   = out_valid && out_ready;
  assign in_ready  = !hold_valid_r || issue_s;
  assign accept_s  = in_valid && in_ready;

  // One-entry holding register for the fetched instruction and its PC
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_r <= 1'b0;
      instr_r      <= 32'h0000_0000;
      pc_r         <= '0;
    end else if (accept_s) begin
      hold_valid_r <= 1'b1;
      instr_r      <= in_instr;
      pc_r         <= in_pc;
    end else if (issue_s || flush) begin
      hold_valid_r <= 1'b0;
    end else begin
      hold_valid_r <= hold_valid_r;
    end
  end

`ifdef DECODE_SCOREBOARD_EN
  logic [31:0] busy_r;
  logic [31:0] busy_nxt_s;

  // Hazards look only at registered busy bits, so a writeback unblocks a cycle later.
  assign hazard_s = (uses_rs1_s && busy_r[instr_r[19:15]]) ||
                    (uses_rs2_s && busy_r[instr_r[24:20]]);

  // Busy update: clear on writeback first so a same-index issue set wins
  always_comb begin
    busy_nxt_s = busy_r;
    if (wb_valid) begin
      busy_nxt_s[wb_rd] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (issue_s && we) begin
      busy_nxt_s[instr_r[11:7]] = 1'b1;
    end else begin
      busy_nxt_s[0] = 1'b0;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard storage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r <= 32'h0000_0000;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end
`else
  logic unused_s;

  assign hazard_s = 1'b0;
  assign unused_s = &{1'b0, wb_valid, wb_rd, uses_rs1_s, uses_rs2_s};
`endif

endmodule
